acc_stream_tx: RTL
==================

ACC_STREAM_TX -- requirements
Module: acc_stream_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning buffer entries (power of two, >=2).
REQ-002 SHALL have parameter PKT_LEN, default 4, meaning beats per packet (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_TDATA  input  8  accumulator result to transmit.
REQ-006 SHALL have port s_TVALID  input  1  s_TDATA valid this cycle.
REQ-007 SHALL have port s_TREADY  output  1  block can accept s_TDATA.
REQ-008 SHALL have port m_TDATA  output  8  transmitted beat.
REQ-009 SHALL have port m_TVALID  output  1  m_TDATA valid.
REQ-010 SHALL have port m_TREADY  input  1  downstream accepts beat.
REQ-011 SHALL have port m_TLAST  output  1  final beat of packet.
REQ-012 SHALL have port flush  input  1  close current packet early.
REQ-013 SHALL have port pkt_count  output  8  packets completed, wraps 255->0.

Function
REQ-014 SHALL accept a beat when s_TVALID && s_TREADY, storing it in a FIFO of DEPTH entries.
REQ-015 SHALL drive s_TREADY = (fill < DEPTH), computed from current fill only; no push on a full cycle even if a pop occurs that cycle.
REQ-016 SHALL present FIFO head on m_TDATA with m_TVALID = (fill > 0); zero-bubble, first-word-fall-through, one-cycle latency from accept to m_TVALID.
REQ-017 SHALL hold m_TDATA, m_TLAST, m_TVALID stable while m_TVALID && !m_TREADY.
REQ-018 SHALL pop on m_TVALID && m_TREADY; simultaneous push and pop leaves fill unchanged.
REQ-019 SHALL keep beat counter beat_cnt (0..PKT_LEN-1), incremented per pop, reset to 0 on a TLAST pop.
REQ-020 SHALL assert m_TLAST when beat_cnt == PKT_LEN-1, or when close_pend is set and fill == 1.
REQ-021 SHALL set close_pend on flush when fill > 0 or beat_cnt > 0; clear it on the TLAST pop; flush with empty FIFO and beat_cnt == 0 is ignored.
REQ-022 SHALL, while close_pend is set, hold s_TREADY low so the packet closes on the already-buffered beats.
REQ-023 SHALL, if flush occurs with beat_cnt > 0 and fill == 0, close on the next pushed beat (TLAST on it).
REQ-024 SHALL use FSM states IDLE (beat_cnt 0, no close_pend), BURST (beat_cnt > 0), CLOSE (close_pend); IDLE->BURST on non-last pop; BURST->IDLE on TLAST pop; IDLE/BURST->CLOSE on qualifying flush; CLOSE->IDLE on TLAST pop.
REQ-025 SHALL increment pkt_count on every TLAST pop, modulo 256.
REQ-026 SHALL give flush priority over a same-cycle normal TLAST only for the beat not yet popped; a beat popped this cycle is unaffected.

Reset
REQ-027 SHALL, with reset high at a clock edge, set fill, pointers, beat_cnt, pkt_count to 0, close_pend to 0, state IDLE.
REQ-028 SHALL drive m_TVALID 0, m_TLAST 0, s_TREADY 0 during reset and m_TDATA 0 after reset; FIFO storage need not be cleared.
REQ-029 SHALL discard buffered beats and any partial packet on reset mid-operation; s_TREADY rises the cycle after reset falls.

Structure
REQ-030 SHALL place DATA_W=8, default DEPTH, default PKT_LEN and the state enum in package acc_stream_pkg.
REQ-031 SHALL implement buffering in one sub-module acc_fifo (FWFT, DEPTH param, fill output); packet logic in acc_stream_tx.

Verification
REQ-032 SHALL test: push 0x11,0x22,0x33,0x44 with m_TREADY=1 -> four beats in order, TLAST on 0x44, pkt_count=1.
REQ-033 SHALL test: m_TREADY=0, push 5 beats -> s_TREADY low after 4th, m_TDATA held 0x11; release -> all 5 in order, TLAST on beat 4 only.
REQ-034 SHALL test: push 0xA0,0xA1, flush -> TLAST on 0xA1, pkt_count=1, next packet starts beat_cnt 0.
REQ-035 SHALL test: flush with empty FIFO in IDLE -> no TLAST, pkt_count unchanged.
REQ-036 SHALL test: reset mid-packet with 3 buffered beats -> m_TVALID 0 next cycle, pkt_count 0, fresh packet of 4 after.
REQ-037 SHALL test: random m_TREADY, 256 packets -> data order preserved, pkt_count wraps to 0.

Source files
------------

// File: rtl/acc_stream_pkg.sv
// Shared constants and FSM state encoding for the accumulator stream transmitter.
package acc_stream_pkg;

  localparam int DATA_W      = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int PKT_LEN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CLOSE = 2'd2
  } state_e;

endpackage

// File: rtl/acc_fifo.sv
// First-word-fall-through FIFO: head entry is always visible on rdata, fill counts entries.
module acc_fifo
  import acc_stream_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       fill_q, fill_d;

  // Pointer and occupancy update; the caller never pushes when full or pops when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // Control state register; pointers and fill return to empty on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage is not reset; stale entries are never visible because fill gates validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign fill  = fill_q;

endmodule

// File: rtl/acc_stream_tx.sv
// Packetizes accumulator results into fixed-length AXI-Stream packets with early close on flush.
module acc_stream_tx
  import acc_stream_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int PKT_LEN = PKT_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_TDATA,
  input  logic              s_TVALID,
  output logic              s_TREADY,
  output logic [DATA_W-1:0] m_TDATA,
  output logic              m_TVALID,
  input  logic              m_TREADY,
  output logic              m_TLAST,
  input  logic              flush,
  output logic [7:0]        pkt_count
);

  localparam int             FW        = $clog2(DEPTH) + 1;
  localparam logic [FW-1:0]  FULL      = FW'(DEPTH);
  localparam logic [FW-1:0]  ONE       = FW'(1);
  localparam logic [7:0]     LAST_BEAT = 8'(PKT_LEN - 1);

  state_e            state_q, state_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [7:0]        pkt_count_q, pkt_count_d;
  logic              rdy_en_q, rdy_en_d;
  logic [FW-1:0]     fill, fill_after;
  logic [DATA_W-1:0] head;
  logic              close_pend, push, pop, last, tlast_pop, flush_hit;

  acc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (s_TDATA),
    .rdata (head),
    .fill  (fill)
  );

  assign close_pend = (state_q == CLOSE);
  // While closing, intake stays shut unless nothing is buffered: then the next beat ends the packet.
  assign s_TREADY   = rdy_en_q && !reset && (fill < FULL) && (!close_pend || fill == '0);
  assign m_TVALID   = !reset && (fill != '0);
  assign last       = (beat_cnt_q == LAST_BEAT) || (close_pend && fill == ONE);
  assign m_TLAST    = m_TVALID && last;
  assign m_TDATA    = m_TVALID ? head : '0;
  assign push       = s_TVALID && s_TREADY;
  assign pop        = m_TVALID && m_TREADY;
  assign tlast_pop  = pop && last;
  assign pkt_count  = pkt_count_q;

  // Next-state: beat/packet counters and FSM; flush judges what remains after this cycle's pop.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    pkt_count_d = pkt_count_q;
    state_d     = state_q;
    rdy_en_d    = 1'b1;
    fill_after  = fill + FW'(push) - FW'(pop);
    if (tlast_pop) begin
      beat_cnt_d  = '0;
      pkt_count_d = pkt_count_q + 8'd1;
    end else if (pop) begin
      beat_cnt_d  = beat_cnt_q + 8'd1;
    end
    flush_hit = flush && !close_pend && (fill_after != '0 || beat_cnt_d != '0);
    case (state_q)
      IDLE: begin
        if (flush_hit)          state_d = CLOSE;
        else if (pop && !last)  state_d = BURST;
      end
      BURST: begin
        if (flush_hit)          state_d = CLOSE;
        else if (tlast_pop)     state_d = IDLE;
      end
      CLOSE: begin
        if (tlast_pop)          state_d = IDLE;
      end
      default:                  state_d = IDLE;
    endcase
  end

  // State register; intake enable is held off for one cycle after reset releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      pkt_count_q <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_count_q <= pkt_count_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

endmodule
